// File: rtl/axi_wr_rsp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wr_rsp_gen
//  Description : Slave-side AXI write-response generator. Queues accepted AW
//                entries ({id, decode error}) and completed W bursts
//                ({error}), pairs them in arrival order and presents one B
//                response per pair through a single holding register.
//  Ports       : clk, rst_n           - clock / async active-low reset
//                aw_push_i/id_i/err_i - AW acceptance record
//                aw_full_o            - AW queue full (hold awready low)
//                w_last_i/w_err_i     - W burst completion record
//                w_full_o             - W queue full (hold wready low)
//                bvalid_o/bready_i    - B channel handshake
//                bid_o/bresp_o        - B channel payload, buser_o tied 0
//                ovf_err_o            - sticky: a push was dropped while full
//                outstanding_o        - AW entries not yet moved into B
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_rsp_gen #(
   parameter int ID_MAX_WIDTH = 12,
   parameter int DEPTH        = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      aw_push_i,
   input  logic [ID_MAX_WIDTH-1:0]   aw_id_i,
   input  logic                      aw_err_i,
   output logic                      aw_full_o,
   input  logic                      w_last_i,
   input  logic                      w_err_i,
   output logic                      w_full_o,
   output logic                      bvalid_o,
   input  logic                      bready_i,
   output logic [ID_MAX_WIDTH-1:0]   bid_o,
   output logic [1:0]                bresp_o,
   output logic                      buser_o,
   output logic                      ovf_err_o,
   output logic [$clog2(DEPTH):0]    outstanding_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int AW_W  = ID_MAX_WIDTH + 1;

   localparam logic [1:0] C_RESP_OKAY   = 2'b00;
   localparam logic [1:0] C_RESP_SLVERR = 2'b10;
   localparam logic [1:0] C_RESP_DECERR = 2'b11;

   // ---------------------------------------------------------------- storage
   logic [AW_W-1:0]         aw_mem_q [DEPTH];
   logic                    w_mem_q  [DEPTH];

   logic [PTR_W-1:0]        aw_wr_ptr_q, aw_wr_ptr_d;
   logic [PTR_W-1:0]        aw_rd_ptr_q, aw_rd_ptr_d;
   logic [CNT_W-1:0]        aw_cnt_q,    aw_cnt_d;
   logic [PTR_W-1:0]        w_wr_ptr_q,  w_wr_ptr_d;
   logic [PTR_W-1:0]        w_rd_ptr_q,  w_rd_ptr_d;
   logic [CNT_W-1:0]        w_cnt_q,     w_cnt_d;

   logic                    bvalid_q,    bvalid_d;
   logic [ID_MAX_WIDTH-1:0] bid_q,       bid_d;
   logic [1:0]              bresp_q,     bresp_d;
   logic                    ovf_q,       ovf_d;

   logic                    aw_full, w_full;
   logic                    aw_wr_en, w_wr_en, load;
   logic [AW_W-1:0]         aw_head;
   logic                    w_head;

   // Full flags come straight from the count registers, so they are glitch-free
   // and already reflect any pop on the previous edge.
   assign aw_full  = (aw_cnt_q == CNT_W'(DEPTH));
   assign w_full   = (w_cnt_q  == CNT_W'(DEPTH));

   // A push while full is dropped even if a pop happens the same edge.
   assign aw_wr_en = aw_push_i && !aw_full;
   assign w_wr_en  = w_last_i  && !w_full;

   assign aw_head  = aw_mem_q[aw_rd_ptr_q];
   assign w_head   = w_mem_q[w_rd_ptr_q];

   // Move a matched pair into B whenever the holding register is free or
   // being emptied this cycle; this sustains one response per cycle.
   assign load = (aw_cnt_q != '0) && (w_cnt_q != '0) && (!bvalid_q || bready_i);

   // --------------------------------------------------------- next state
   always_comb begin
      aw_wr_ptr_d = aw_wr_ptr_q;
      aw_rd_ptr_d = aw_rd_ptr_q;
      aw_cnt_d    = aw_cnt_q;
      w_wr_ptr_d  = w_wr_ptr_q;
      w_rd_ptr_d  = w_rd_ptr_q;
      w_cnt_d     = w_cnt_q;
      bvalid_d    = bvalid_q;
      bid_d       = bid_q;
      bresp_d     = bresp_q;
      ovf_d       = ovf_q;

      if (aw_wr_en) aw_wr_ptr_d = aw_wr_ptr_q + PTR_W'(1);
      if (w_wr_en)  w_wr_ptr_d  = w_wr_ptr_q  + PTR_W'(1);
      if (load) begin
         aw_rd_ptr_d = aw_rd_ptr_q + PTR_W'(1);
         w_rd_ptr_d  = w_rd_ptr_q  + PTR_W'(1);
      end

      case ({aw_wr_en, load})
         2'b10:   aw_cnt_d = aw_cnt_q + CNT_W'(1);
         2'b01:   aw_cnt_d = aw_cnt_q - CNT_W'(1);
         default: aw_cnt_d = aw_cnt_q;
      endcase
      case ({w_wr_en, load})
         2'b10:   w_cnt_d = w_cnt_q + CNT_W'(1);
         2'b01:   w_cnt_d = w_cnt_q - CNT_W'(1);
         default: w_cnt_d = w_cnt_q;
      endcase

      if ((aw_push_i && aw_full) || (w_last_i && w_full)) ovf_d = 1'b1;

      if (load) begin
         bvalid_d = 1'b1;
         bid_d    = aw_head[AW_W-1:1];
         // Decode error dominates a slave error from the data phase.
         if (aw_head[0])  bresp_d = C_RESP_DECERR;
         else if (w_head) bresp_d = C_RESP_SLVERR;
         else             bresp_d = C_RESP_OKAY;
      end else if (bready_i) begin
         bvalid_d = 1'b0;
      end
   end

   // -------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wr_ptr_q <= '0;
         aw_rd_ptr_q <= '0;
         aw_cnt_q    <= '0;
         w_wr_ptr_q  <= '0;
         w_rd_ptr_q  <= '0;
         w_cnt_q     <= '0;
         bvalid_q    <= 1'b0;
         bid_q       <= '0;
         bresp_q     <= C_RESP_OKAY;
         ovf_q       <= 1'b0;
      end else begin
         aw_wr_ptr_q <= aw_wr_ptr_d;
         aw_rd_ptr_q <= aw_rd_ptr_d;
         aw_cnt_q    <= aw_cnt_d;
         w_wr_ptr_q  <= w_wr_ptr_d;
         w_rd_ptr_q  <= w_rd_ptr_d;
         w_cnt_q     <= w_cnt_d;
         bvalid_q    <= bvalid_d;
         bid_q       <= bid_d;
         bresp_q     <= bresp_d;
         ovf_q       <= ovf_d;
      end
   end

   // Entry storage needs no reset: an entry is only read once its count
   // says it was written.
   always_ff @(posedge clk) begin
      if (aw_wr_en) aw_mem_q[aw_wr_ptr_q] <= {aw_id_i, aw_err_i};
      if (w_wr_en)  w_mem_q[w_wr_ptr_q]   <= w_err_i;
   end

   // ---------------------------------------------------------- outputs
   assign aw_full_o     = aw_full;
   assign w_full_o      = w_full;
   assign bvalid_o      = bvalid_q;
   assign bid_o         = bid_q;
   assign bresp_o       = bresp_q;
   assign buser_o       = 1'b0;
   assign ovf_err_o     = ovf_q;
   assign outstanding_o = aw_cnt_q;

endmodule
`default_nettype wire
